// File: rtl/tcdm_bank_resp.sv
// Single-ported TCDM bank responder for one slave port of the TCDM interconnect.
// Zero-fill init sequencer, periodic grant-stall injector and saturating access counters.
module tcdm_bank_resp #(
    parameter int NumWords    = 256,
    parameter int AddWidth    = 8,
    parameter int DataWidth   = 32,
    parameter int InitZero    = 1,
    parameter int StallPeriod = 0,
    parameter int CntWidth    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddWidth-1:0]  add_i,
    input  logic                 wen_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic                 init_done_o,
    output logic [CntWidth-1:0]  rd_cnt_o,
    output logic [CntWidth-1:0]  wr_cnt_o
);

    localparam int IdxWidth   = $clog2(NumWords);
    localparam int StallMod   = (StallPeriod >= 2) ? StallPeriod : 2;
    localparam int StallWidth = $clog2(StallMod);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                state_q;
    logic [IdxWidth-1:0]   init_ptr_q;
    logic                  ready_q;
    logic [StallWidth-1:0] stall_cnt_q;
    logic [DataWidth-1:0]  mem_q [NumWords];
    logic [DataWidth-1:0]  rdata_q;
    logic                  err_q;
    logic [CntWidth-1:0]   rd_cnt_q;
    logic [CntWidth-1:0]   wr_cnt_q;

    logic                  stall;
    logic                  gnt;
    logic                  acc;
    logic                  in_range;
    logic [IdxWidth-1:0]   idx;

    // Handshake: a request is accepted in every cycle where req_i && gnt_o.
    // gnt_o never looks at req_i; an ungranted request has no side effects and
    // the master keeps req_i/add_i/wen_i/data_i stable until it is granted.
    assign stall = (StallPeriod >= 2) && (stall_cnt_q == StallWidth'(StallMod - 1));
    assign gnt   = ready_q && !stall;
    assign acc   = req_i && gnt;
    assign idx   = add_i[IdxWidth-1:0];

    if (AddWidth > IdxWidth) begin : g_hi_bits
        assign in_range = (add_i[AddWidth-1:IdxWidth] == '0);
    end else begin : g_no_hi_bits
        assign in_range = 1'b1;
    end

    // ready_q is the registered view of state_q == READY
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (InitZero != 0) ? INIT : READY;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_ptr_q <= init_ptr_q + 1'b1;
                    if (init_ptr_q == IdxWidth'(NumWords - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The array itself has no reset; INIT is what clears it
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == INIT) begin
                mem_q[init_ptr_q] <= '0;
            end else if (acc && wen_i && in_range) begin
                mem_q[idx] <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (ready_q) begin
                stall_cnt_q <= (stall_cnt_q == StallWidth'(StallMod - 1)) ? '0 : stall_cnt_q + 1'b1;
            end
            if (acc) begin
                if (wen_i) begin
                    wr_cnt_q <= (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 1'b1;
                    err_q    <= !in_range;
                end else begin
                    rd_cnt_q <= (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 1'b1;
                    rdata_q  <= in_range ? mem_q[idx] : '0;
                    err_q    <= !in_range;
                end
            end
        end
    end

    assign gnt_o       = gnt;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign init_done_o = ready_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Bench for tcdm_bank_resp: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the bank kept in this file.
module tb_tcdm_bank_resp;

    localparam int NW   = 128;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int SP   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          gnt;
    logic [AW-1:0] add = '0;
    logic          wen = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          err;
    logic          init_done;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;

    tcdm_bank_resp #(
        .NumWords   (NW),
        .AddWidth   (AW),
        .DataWidth  (DW),
        .InitZero   (1),
        .StallPeriod(SP),
        .CntWidth   (CW)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .gnt_o      (gnt),
        .add_i      (add),
        .wen_i      (wen),
        .data_i     (wdata),
        .rdata_o    (rdata),
        .err_o      (err),
        .init_done_o(init_done),
        .rd_cnt_o   (rd_cnt),
        .wr_cnt_o   (wr_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errs   = 0;

    // reference model
    bit            m_valid = 1'b0;
    bit            m_ready = 1'b0;
    int            m_left  = NW;
    int            m_rpos  = 0;
    int            m_rd    = 0;
    int            m_wr    = 0;
    bit            m_err   = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_mem [NW];
    logic          obs_gnt;

    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // In READY cycle n (1-based) the grant is withheld when n is a multiple of SP
    function automatic bit model_gnt();
        return m_ready && (((m_rpos + 1) % SP) != 0);
    endfunction

    // One clock cycle: drive, check grant, clock, update model, check registered outputs
    task automatic step(input logic r, input logic rq, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, output logic g);
        bit eg;
        rst = r; req = rq; wen = w; add = a; wdata = d;
        #1;
        eg      = model_gnt();
        obs_gnt = gnt;
        if (m_valid) check("gnt", 32'(gnt), 32'(eg));
        g = rq && eg;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1; m_ready = 1'b0; m_left = NW; m_rpos = 0;
            m_rd = 0; m_wr = 0; m_err = 1'b0; m_rdata = '0;
        end else if (!m_ready) begin
            m_err = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < NW; i++) m_mem[i] = '0;
            end
        end else begin
            m_rpos++;
            m_err = 1'b0;
            if (g) begin
                if (w) begin
                    if (int'(a) < NW) m_mem[int'(a)] = d;
                    else m_err = 1'b1;
                    m_wr = (m_wr < MAXC) ? m_wr + 1 : MAXC;
                end else begin
                    m_rdata = (int'(a) < NW) ? m_mem[int'(a)] : '0;
                    m_err   = !(int'(a) < NW);
                    m_rd    = (m_rd < MAXC) ? m_rd + 1 : MAXC;
                end
            end
        end
        #1;
        if (m_valid) begin
            check("init_done", 32'(init_done), 32'(m_ready));
            check("err", 32'(err), 32'(m_err));
            check("rdata", rdata, m_rdata);
            check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
            check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, g);
    endtask

    task automatic do_reset();
        logic g;
        step(1'b1, 1'b0, 1'b0, '0, '0, g);
        step(1'b1, 1'b0, 1'b0, '0, '0, g);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < NW + 8) begin
            idle(1);
            n++;
        end
    endtask

    // Present one access and hold it until it is granted (bounded)
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic g = 1'b0;
        int   tries = 0;
        while (!g && tries < 8) begin
            step(1'b0, 1'b1, w, a, d, g);
            tries++;
        end
        check("xfer_granted", 32'(g), 32'd1);
    endtask

    // Count cycles until init_done rises, bounded
    task automatic count_init(output int n);
        n = 0;
        while (!init_done && n < NW + 10) begin
            idle(1);
            n++;
        end
    endtask

    initial begin
        logic          g;
        int            n;
        int            n_gnt;
        int            n_upd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] wr_val [16];

        // reset values and init length
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        count_init(n);
        check("init_len", n, NW);

        // stall pattern on writes from READY cycle 1, then on reads
        a = '0; n_gnt = 0;
        for (int i = 0; i < 12; i++) begin
            d = $urandom;
            step(1'b0, 1'b1, 1'b1, a, d, g);
            check("stall_pat_wr", 32'(obs_gnt), 32'(((i + 1) % SP) != 0));
            if (obs_gnt) n_gnt++;
            if (g) begin
                wr_val[a] = d;
                a++;
            end
        end
        check("stall_wr_grants", n_gnt, 9);
        a = '0; n_upd = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, a, '0, g);
            check("stall_pat_rd", 32'(obs_gnt), 32'(((i + 1) % SP) != 0));
            if (g) begin
                exp_q.push_back(wr_val[a]);
                a++;
                n_upd++;
                check("stall_rd_data", rdata, exp_q.pop_front());
            end
        end
        check("stall_rd_updates", n_upd, 9);

        // write then read back, data holds over idle cycles
        do_reset();
        wait_ready();
        xfer(1'b1, 8'h10, 32'hDEADBEEF);
        xfer(1'b0, 8'h10, '0);
        check("rd_10", rdata, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("rd_hold", rdata, 32'hDEADBEEF);
        end
        check("wr_cnt_1", 32'(wr_cnt), 32'd1);
        check("rd_cnt_1", 32'(rd_cnt), 32'd1);
        xfer(1'b0, 8'h7F, '0);
        check("rd_7f_zero", rdata, 32'd0);

        // out-of-range accesses
        xfer(1'b1, 8'h00, 32'h12345678);
        xfer(1'b1, 8'h80, 32'hFFFFFFFF);
        check("oor_wr_err", 32'(err), 32'd1);
        xfer(1'b0, 8'h80, '0);
        check("oor_rd_err", 32'(err), 32'd1);
        check("oor_rd_data", rdata, 32'd0);
        idle(1);
        check("oor_err_pulse", 32'(err), 32'd0);
        xfer(1'b0, 8'h00, '0);
        check("word0_kept", rdata, 32'h12345678);

        // reset in the middle of INIT restarts the sequence
        do_reset();
        idle(99);
        step(1'b1, 1'b0, 1'b0, '0, '0, g);
        check("midrst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
        count_init(n);
        check("midrst_init_len", n, NW);

        // read counter saturation
        for (int i = 0; i < 20; i++) begin
            xfer(1'b0, AW'($urandom_range(0, NW - 1)), '0);
            if (i == 14) check("rd_sat_15", 32'(rd_cnt), 32'd15);
        end
        check("rd_sat_20", 32'(rd_cnt), 32'd15);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) a = AW'($urandom_range(0, NW - 1));
            else a = AW'($urandom_range(0, (1 << AW) - 1));
            step(1'b0, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), a, $urandom, g);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
